pixel_window_3x3: RTL and testbench
===================================

PIXEL_WINDOW_3X3 -- requirements
Module: pixel_window_3x3

Interface
REQ-001: Parameter LINE_WIDTH, default 640, pixels per line.
REQ-002: Parameter LINE_COUNT, default 480, lines per frame.
REQ-003: clk25  input  1  pixel clock; all logic rising-edge on clk25; single clock domain.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: pixel_in  input  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}.
REQ-006: pixel_valid  input  1  pixel_in accepted on every clk25 edge where high; no backpressure.
REQ-007: frame_start  input  1  qualifies the accepted pixel as frame pixel (0,0); ignored when pixel_valid low.
REQ-008: win_lu, win_lm, win_ld, win_mu, win_mm, win_md, win_ru, win_rm, win_rd  output  12 each  3x3 window; l/m/r = column left/centre/right, u/m/d = row up/middle/down.
REQ-009: win_valid  output  1  window outputs hold a complete in-frame window.
REQ-010: win_x  output  10  column of win_mm pixel.
REQ-011: win_y  output  9  row of win_mm pixel.

Function
REQ-012: Column counter col (0..LINE_WIDTH-1) and row counter row (0..LINE_COUNT-1) shall advance only on accepted pixels.
REQ-013: Accepted pixel at col=LINE_WIDTH-1 shall wrap col to 0 and increment row; at row=LINE_COUNT-1 also wrap row to 0.
REQ-014: Accepted pixel with frame_start=1 shall be treated as (0,0) regardless of counter state; counters then advance to col=1,row=0.
REQ-015: Two line buffers of LINE_WIDTH x 12 bits: lb1 holds line row-1, lb2 holds line row-2.
REQ-016: On accepted pixel at column c: read lb1[c], lb2[c]; write lb2[c] <= old lb1[c], lb1[c] <= pixel_in, same edge.
REQ-017: Column shift on accepted pixel: left taps <= middle taps, middle taps <= right taps, right taps <= {u=lb2[c], m=lb1[c], d=pixel_in}.
REQ-018: Window outputs registered; update exactly one clk25 after the accepted pixel; hold when pixel_valid low.
REQ-019: win_valid shall be 1 in the cycle after an accepted pixel with row>=2 and col>=2 (evaluated on that pixel's coordinates), else 0.
REQ-020: With win_valid=1, win_rd = pixel (col,row), win_mm = pixel (col-1,row-1), win_lu = pixel (col-2,row-2).
REQ-021: win_x = col-1, win_y = row-1 of the triggering pixel; registered alongside the window.
REQ-022: Border windows (row<2 or col<2) shall never assert win_valid; no padding or replication.
REQ-023: Gaps in pixel_valid of any length shall not alter window content versus gap-free stream.
REQ-024: Per full frame exactly (LINE_WIDTH-2)*(LINE_COUNT-2) win_valid pulses.
REQ-025: Line buffer storage shall infer block/distributed RAM; one read and one write per cycle.

Reset
REQ-026: rst_n low shall immediately clear col, row, all nine taps, win_x, win_y to 0 and win_valid to 0.
REQ-027: Line buffer contents are not reset; stale data shall never reach a window with win_valid=1.
REQ-028: After reset release, first accepted pixel is (0,0) whether or not frame_start is high.
REQ-029: Reset mid-frame discards the partial frame; no win_valid until row>=2, col>=2 of the new count.

Verification
REQ-030: Assert rst_n=0 mid-stream -> all outputs 0 in same cycle, win_valid 0 until two lines plus two pixels received.
REQ-031: LINE_WIDTH=8, LINE_COUNT=6, pixel=12'h{0,row,col} continuous -> first win_valid after pixel (2,2): win_lu=12'h000, win_mm=12'h011, win_rd=12'h022, win_x=1, win_y=1.
REQ-032: Same frame -> exactly 6 pulses per row for rows 2..5, 24 per frame, none for col 0/1; frame 2 identical.
REQ-033: Same frame with random 0-5 cycle pixel_valid gaps -> window sequence identical to gap-free run.
REQ-034: frame_start asserted on pixel at counter (5,3) -> treated as (0,0); next win_valid only after new pixel (2,2), win_x=1, win_y=1.
REQ-035: frame_start high with pixel_valid low -> counters unchanged, no output change.

Source files
------------

// File: rtl/pixel_window_3x3_if.sv
// Pixel stream in, 3x3 window out, for pixel_window_3x3.
// master drives the pixel stream; slave is the windowing block.
interface pixel_window_3x3_if;
  logic [11:0] pixel_in;
  logic        pixel_valid;
  logic        frame_start;
  logic [11:0] win_lu, win_lm, win_ld;
  logic [11:0] win_mu, win_mm, win_md;
  logic [11:0] win_ru, win_rm, win_rd;
  logic        win_valid;
  logic [9:0]  win_x;
  logic [8:0]  win_y;

  modport master (
    output pixel_in, pixel_valid, frame_start,
    input  win_lu, win_lm, win_ld, win_mu, win_mm, win_md,
           win_ru, win_rm, win_rd, win_valid, win_x, win_y
  );

  modport slave (
    input  pixel_in, pixel_valid, frame_start,
    output win_lu, win_lm, win_ld, win_mu, win_mm, win_md,
           win_ru, win_rm, win_rd, win_valid, win_x, win_y
  );
endinterface

// File: rtl/pixel_window_3x3.sv
// 3x3 sliding window over a raster pixel stream using two line buffers.
// The window is registered and valid only when fully inside the frame.
module pixel_window_3x3 #(
  parameter int unsigned LINE_WIDTH = 640,
  parameter int unsigned LINE_COUNT = 480
) (
  input logic               clk25,
  input logic               rst_n,
  pixel_window_3x3_if.slave pix
);

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned COL_W  = 10;
  localparam int unsigned ROW_W  = 9;
  localparam int unsigned ADDR_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

  logic [COL_W-1:0] col, curCol, nextCol;
  logic [ROW_W-1:0] row, curRow, nextRow;
  logic [ADDR_W-1:0] addr;

  logic [PIX_W-1:0] lb1 [LINE_WIDTH];
  logic [PIX_W-1:0] lb2 [LINE_WIDTH];
  logic [PIX_W-1:0] lb1Rd, lb2Rd;

  logic [PIX_W-1:0] tapLu, tapLm, tapLd;
  logic [PIX_W-1:0] tapMu, tapMm, tapMd;
  logic [PIX_W-1:0] tapRu, tapRm, tapRd;
  logic             winValid;
  logic [COL_W-1:0] winX;
  logic [ROW_W-1:0] winY;

  // frame_start forces the current pixel to (0,0) before the usual advance
  always_comb begin
    curCol  = pix.frame_start ? '0 : col;
    curRow  = pix.frame_start ? '0 : row;
    nextCol = curCol + COL_W'(1);
    nextRow = curRow;
    if (curCol == COL_W'(LINE_WIDTH - 1)) begin
      nextCol = '0;
      nextRow = (curRow == ROW_W'(LINE_COUNT - 1)) ? '0 : curRow + ROW_W'(1);
    end
  end

  assign addr  = ADDR_W'(curCol);
  assign lb1Rd = lb1[addr];
  assign lb2Rd = lb2[addr];

  // Line buffers are plain RAM: no reset, one read and one write per pixel
  always_ff @(posedge clk25) begin
    if (pix.pixel_valid) begin
      lb1[addr] <= pix.pixel_in;
      lb2[addr] <= lb1Rd;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      col      <= '0;
      row      <= '0;
      tapLu    <= '0;
      tapLm    <= '0;
      tapLd    <= '0;
      tapMu    <= '0;
      tapMm    <= '0;
      tapMd    <= '0;
      tapRu    <= '0;
      tapRm    <= '0;
      tapRd    <= '0;
      winValid <= 1'b0;
      winX     <= '0;
      winY     <= '0;
    end else begin
      winValid <= pix.pixel_valid && (curCol >= COL_W'(2)) && (curRow >= ROW_W'(2));
      if (pix.pixel_valid) begin
        col   <= nextCol;
        row   <= nextRow;
        tapLu <= tapMu;
        tapLm <= tapMm;
        tapLd <= tapMd;
        tapMu <= tapRu;
        tapMm <= tapRm;
        tapMd <= tapRd;
        tapRu <= lb2Rd;
        tapRm <= lb1Rd;
        tapRd <= pix.pixel_in;
        winX  <= curCol - COL_W'(1);
        winY  <= curRow - ROW_W'(1);
      end
    end
  end

  assign pix.win_lu    = tapLu;
  assign pix.win_lm    = tapLm;
  assign pix.win_ld    = tapLd;
  assign pix.win_mu    = tapMu;
  assign pix.win_mm    = tapMm;
  assign pix.win_md    = tapMd;
  assign pix.win_ru    = tapRu;
  assign pix.win_rm    = tapRm;
  assign pix.win_rd    = tapRd;
  assign pix.win_valid = winValid;
  assign pix.win_x     = winX;
  assign pix.win_y     = winY;

endmodule

// File: tb/tb_pixel_window_3x3.sv
// Scoreboard bench for pixel_window_3x3 on an 8x6 frame with pixel = {0,row,col}.
module tb_pixel_window_3x3;

  localparam int unsigned LW = 8;
  localparam int unsigned LC = 6;
  localparam int unsigned FRAME = LW * LC;
  localparam int unsigned PULSES = (LW - 2) * (LC - 2);

  typedef struct packed {
    logic [11:0] lu, lm, ld, mu, mm, md, ru, rm, rd;
    logic [9:0]  x;
    logic [8:0]  y;
  } win_t;

  logic clk25 = 1'b0;
  logic rst_n;
  always #5 clk25 = ~clk25;

  pixel_window_3x3_if bus ();

  pixel_window_3x3 #(.LINE_WIDTH(LW), .LINE_COUNT(LC)) dut (
    .clk25 (clk25),
    .rst_n (rst_n),
    .pix   (bus)
  );

  int   checks   = 0;
  int   errors   = 0;
  int   pulseCnt = 0;
  int   tbCol    = 0;
  int   tbRow    = 0;
  int   base;
  win_t q[$];
  win_t lastExp;

  function automatic logic [11:0] pixAt(input int c, input int r);
    return {4'h0, 4'(r), 4'(c)};
  endfunction

  function automatic win_t expWin(input int c, input int r);
    win_t w;
    w.lu = pixAt(c - 2, r - 2); w.lm = pixAt(c - 2, r - 1); w.ld = pixAt(c - 2, r);
    w.mu = pixAt(c - 1, r - 2); w.mm = pixAt(c - 1, r - 1); w.md = pixAt(c - 1, r);
    w.ru = pixAt(c, r - 2);     w.rm = pixAt(c, r - 1);     w.rd = pixAt(c, r);
    w.x  = 10'(c - 1);
    w.y  = 9'(r - 1);
    return w;
  endfunction

  function automatic win_t dutWin();
    win_t w;
    w.lu = bus.win_lu; w.lm = bus.win_lm; w.ld = bus.win_ld;
    w.mu = bus.win_mu; w.mm = bus.win_mm; w.md = bus.win_md;
    w.ru = bus.win_ru; w.rm = bus.win_rm; w.rd = bus.win_rd;
    w.x  = bus.win_x;
    w.y  = bus.win_y;
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every window pulse must match the oldest expected window
  always @(negedge clk25) begin
    if (rst_n && bus.win_valid) begin
      win_t e;
      pulseCnt++;
      check("pending_expect", 128'(q.size() != 0), 128'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        check("window", 128'(dutWin()), 128'(e));
      end
    end
  end

  task automatic sendOne(input bit fs, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(posedge clk25); #1;
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'($urandom_range(0, 1));
    end
    @(posedge clk25); #1;
    if (fs) begin
      tbCol = 0;
      tbRow = 0;
    end
    bus.pixel_valid = 1'b1;
    bus.frame_start = fs;
    bus.pixel_in    = pixAt(tbCol, tbRow);
    if (tbCol >= 2 && tbRow >= 2) begin
      lastExp = expWin(tbCol, tbRow);
      q.push_back(lastExp);
    end
    tbCol++;
    if (tbCol == int'(LW)) begin
      tbCol = 0;
      tbRow = (tbRow == int'(LC) - 1) ? 0 : tbRow + 1;
    end
  endtask

  task automatic sendPixels(input int n, input int maxGap);
    for (int i = 0; i < n; i++)
      sendOne(1'b0, (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
  endtask

  task automatic idle();
    @(posedge clk25); #1;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic pulseCheck(input string name, input int from);
    idle();
    @(negedge clk25); #1;
    check(name, 128'(pulseCnt - from), 128'(PULSES));
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.frame_start = 1'b0;
    bus.pixel_in    = '0;
    #2;
    check("reset_window", 128'(dutWin()), 128'(0));
    check("reset_valid", 128'(bus.win_valid), 128'(0));
    repeat (3) @(negedge clk25);
    rst_n = 1'b1;

    // Frame 1: stop right after pixel (2,2) to inspect the first window
    base = pulseCnt;
    sendPixels(2 * LW + 3, 0);
    idle();
    @(negedge clk25); #1;
    check("first_lu", 128'(bus.win_lu), 128'(12'h000));
    check("first_mm", 128'(bus.win_mm), 128'(12'h011));
    check("first_rd", 128'(bus.win_rd), 128'(12'h022));
    check("first_x", 128'(bus.win_x), 128'(1));
    check("first_y", 128'(bus.win_y), 128'(1));
    sendPixels(FRAME - (2 * LW + 3), 0);
    pulseCheck("frame1_pulses", base);

    base = pulseCnt;
    sendPixels(FRAME, 0);
    pulseCheck("frame2_pulses", base);

    // Random gaps, with frame_start toggling while pixel_valid is low
    base = pulseCnt;
    sendPixels(FRAME, 5);
    pulseCheck("gap_frame_pulses", base);

    // Hold with frame_start high but no valid pixel, then restart at (5,3)
    sendPixels(3 * LW + 5, 0);
    idle();
    bus.frame_start = 1'b1;
    repeat (3) begin
      @(posedge clk25); #1;
      bus.pixel_valid = 1'b0;
      bus.frame_start = 1'b1;
      @(negedge clk25); #1;
      check("hold_window", 128'(dutWin()), 128'(lastExp));
      check("hold_valid", 128'(bus.win_valid), 128'(0));
    end
    base = pulseCnt;
    sendOne(1'b1, 0);
    sendPixels(FRAME - 1, 0);
    pulseCheck("restart_frame_pulses", base);

    // Reset mid-frame with a non-zero window on the outputs
    sendPixels(3 * LW + 5, 0);
    idle();
    @(negedge clk25); #1;
    rst_n = 1'b0;
    #1;
    check("midreset_window", 128'(dutWin()), 128'(0));
    check("midreset_valid", 128'(bus.win_valid), 128'(0));
    check("midreset_pending", 128'(q.size()), 128'(0));
    q.delete();
    tbCol = 0;
    tbRow = 0;
    repeat (2) @(negedge clk25);
    rst_n = 1'b1;
    base = pulseCnt;
    sendPixels(FRAME, 0);
    pulseCheck("post_reset_pulses", base);

    repeat (3) idle();
    check("final_pending", 128'(q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
